// File: rtl/csi2_packet_parser.sv
// CSI-2 single-lane packet layer: decodes DI/WC/ECC headers, emits frame/line
// events and payload bytes, checks long-packet CRC-16 and truncation.
module csi2_packet_parser #(
  parameter bit          CHECK_CRC = 1'b1,
  parameter logic [15:0] MAX_WC    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        in_we,
  input  logic [7:0]  in_data,
  output logic        frame_start,
  output logic        frame_end,
  output logic        line_start,
  output logic        line_end,
  output logic        pix_valid,
  output logic [7:0]  pix_data,
  output logic [5:0]  data_type,
  output logic [1:0]  vchan,
  output logic [15:0] word_count,
  output logic [7:0]  ecc,
  output logic        crc_err,
  output logic        len_err,
  output logic [15:0] pkt_count
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_PAY   = 3'd2;
  localparam logic [2:0] S_CRC   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [1:0]  hdr_cnt_q, hdr_cnt_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  crc_lo_q, crc_lo_d;
  logic        crc_ph_q, crc_ph_d;
  logic [5:0]  dt_q, dt_d;
  logic [1:0]  vc_q, vc_d;
  logic [15:0] wc_q, wc_d;
  logic [7:0]  ecc_q, ecc_d;
  logic [15:0] pkt_q, pkt_d;
  logic        fs_q, fs_d, fe_q, fe_d, ls_q, ls_d, le_q, le_d;
  logic        pv_q, pv_d, cerr_q, cerr_d, lerr_q, lerr_d;
  logic [7:0]  pd_q, pd_d;
  logic [16:0] wc_room;

  // Reflected CRC-16 (0x8408), LSB-first per byte.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  // Borrow out of MAX_WC - WC means WC exceeds the limit.
  assign wc_room = {1'b0, MAX_WC} - {1'b0, wc_q};

  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    rem_d     = rem_q;
    crc_d     = crc_q;
    crc_lo_d  = crc_lo_q;
    crc_ph_d  = crc_ph_q;
    dt_d      = dt_q;
    vc_d      = vc_q;
    wc_d      = wc_q;
    ecc_d     = ecc_q;
    pkt_d     = pkt_q;
    pd_d      = pd_q;
    fs_d      = 1'b0;
    fe_d      = 1'b0;
    ls_d      = 1'b0;
    le_d      = 1'b0;
    pv_d      = 1'b0;
    cerr_d    = 1'b0;
    lerr_d    = 1'b0;
    case (state_q)
      S_IDLE: if (in_we) begin
        vc_d      = in_data[7:6];
        dt_d      = in_data[5:0];
        hdr_cnt_d = 2'd1;
        crc_d     = 16'hFFFF;
        state_d   = S_HDR;
      end
      S_HDR: if (!in_we) begin
        lerr_d  = 1'b1;
        state_d = S_IDLE;
      end else begin
        case (hdr_cnt_q)
          2'd1: begin wc_d[7:0]  = in_data; hdr_cnt_d = 2'd2; end
          2'd2: begin wc_d[15:8] = in_data; hdr_cnt_d = 2'd3; end
          default: begin
            ecc_d = in_data;
            if (dt_q[5:4] == 2'b00) begin
              fs_d    = (dt_q == 6'h00);
              fe_d    = (dt_q == 6'h01);
              ls_d    = (dt_q == 6'h02);
              le_d    = (dt_q == 6'h03);
              pkt_d   = pkt_q + 16'd1;
              state_d = S_DRAIN;
            end else if (wc_room[16]) begin
              lerr_d  = 1'b1;
              state_d = S_DRAIN;
            end else if (wc_q == 16'd0) begin
              crc_ph_d = 1'b0;
              state_d  = S_CRC;
            end else begin
              rem_d   = wc_q;
              state_d = S_PAY;
            end
          end
        endcase
      end
      S_PAY: if (!in_we) begin
        lerr_d  = 1'b1;
        state_d = S_IDLE;
      end else begin
        pv_d  = 1'b1;
        pd_d  = in_data;
        crc_d = crc_step(crc_q, in_data);
        rem_d = rem_q - 16'd1;
        if (rem_q == 16'd1) begin
          crc_ph_d = 1'b0;
          state_d  = S_CRC;
        end
      end
      S_CRC: if (!in_we) begin
        lerr_d  = 1'b1;
        state_d = S_IDLE;
      end else if (!crc_ph_q) begin
        crc_lo_d = in_data;
        crc_ph_d = 1'b1;
      end else begin
        cerr_d  = CHECK_CRC && ({in_data, crc_lo_q} != crc_q);
        pkt_d   = pkt_q + 16'd1;
        state_d = S_DRAIN;
      end
      S_DRAIN: if (!in_we) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q   <= S_IDLE;
      hdr_cnt_q <= 2'd0;
      rem_q     <= 16'd0;
      crc_q     <= 16'hFFFF;
      crc_lo_q  <= 8'd0;
      crc_ph_q  <= 1'b0;
      dt_q      <= 6'd0;
      vc_q      <= 2'd0;
      wc_q      <= 16'd0;
      ecc_q     <= 8'd0;
      pkt_q     <= 16'd0;
      pd_q      <= 8'd0;
      fs_q      <= 1'b0;
      fe_q      <= 1'b0;
      ls_q      <= 1'b0;
      le_q      <= 1'b0;
      pv_q      <= 1'b0;
      cerr_q    <= 1'b0;
      lerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      rem_q     <= rem_d;
      crc_q     <= crc_d;
      crc_lo_q  <= crc_lo_d;
      crc_ph_q  <= crc_ph_d;
      dt_q      <= dt_d;
      vc_q      <= vc_d;
      wc_q      <= wc_d;
      ecc_q     <= ecc_d;
      pkt_q     <= pkt_d;
      pd_q      <= pd_d;
      fs_q      <= fs_d;
      fe_q      <= fe_d;
      ls_q      <= ls_d;
      le_q      <= le_d;
      pv_q      <= pv_d;
      cerr_q    <= cerr_d;
      lerr_q    <= lerr_d;
    end
  end

  assign frame_start = fs_q;
  assign frame_end   = fe_q;
  assign line_start  = ls_q;
  assign line_end    = le_q;
  assign pix_valid   = pv_q;
  assign pix_data    = pd_q;
  assign data_type   = dt_q;
  assign vchan       = vc_q;
  assign word_count  = wc_q;
  assign ecc         = ecc_q;
  assign crc_err     = cerr_q;
  assign len_err     = lerr_q;
  assign pkt_count   = pkt_q;
endmodule

// File: tb/tb_csi2_packet_parser.sv
// Directed bench for csi2_packet_parser; payload bytes are checked through a
// scoreboard queue, event pulses are counted by a negedge monitor.
module tb_csi2_packet_parser;
  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        in_we = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        frame_start, frame_end, line_start, line_end;
  logic        pix_valid, crc_err, len_err;
  logic [7:0]  pix_data, ecc;
  logic [5:0]  data_type;
  logic [1:0]  vchan;
  logic [15:0] word_count, pkt_count;

  int n_cmp = 0, n_err = 0;
  int fs_n = 0, fe_n = 0, ls_n = 0, le_n = 0, ce_n = 0, len_n = 0, pix_n = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  csi2_packet_parser #(.CHECK_CRC(1'b1), .MAX_WC(16'h0100)) dut (
    .clk(clk), .resetb(resetb), .in_we(in_we), .in_data(in_data),
    .frame_start(frame_start), .frame_end(frame_end),
    .line_start(line_start), .line_end(line_end),
    .pix_valid(pix_valid), .pix_data(pix_data),
    .data_type(data_type), .vchan(vchan), .word_count(word_count), .ecc(ecc),
    .crc_err(crc_err), .len_err(len_err), .pkt_count(pkt_count)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] b, input bit pix = 1'b0);
    in_we   = 1'b1;
    in_data = b;
    if (pix) sb.push_back(b);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_we = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) if (resetb) begin
    if (frame_start) fs_n++;
    if (frame_end)   fe_n++;
    if (line_start)  ls_n++;
    if (line_end)    le_n++;
    if (crc_err)     ce_n++;
    if (len_err)     len_n++;
    if (pix_valid) begin
      pix_n++;
      check("sb_nonempty", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) check("pix_data", 32'(pix_data), 32'(sb.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sequence did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_pkt_count", 32'(pkt_count), 0);
    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_outs", 32'({frame_start, frame_end, line_start, line_end, crc_err, len_err}), 0);
    check("rst_hdr", 32'({data_type, vchan, word_count, ecc}), 0);
    resetb = 1'b1;
    @(posedge clk); #1;

    // FS short packet
    put(8'h00); put(8'h01); put(8'h00); put(8'h5A);
    check("fs_pulse", 32'(frame_start), 1);
    idle(3);
    check("fs_count", fs_n, 1);
    check("fs_wc", 32'(word_count), 'h0001);
    check("fs_vchan", 32'(vchan), 0);
    check("fs_ecc", 32'(ecc), 'h5A);
    check("fs_pkt", 32'(pkt_count), 1);
    check("fs_nopix", pix_n, 0);

    // Long packet, good CRC over "123456789"
    put(8'h2A); put(8'h09); put(8'h00); put(8'h11);
    for (int i = 0; i < 9; i++) put(8'h31 + 8'(i), 1'b1);
    put(8'h91); put(8'h6F);
    check("good_crc_err", 32'(crc_err), 0);
    idle(3);
    check("good_pix_n", pix_n, 9);
    check("good_ce_n", ce_n, 0);
    check("good_pkt", 32'(pkt_count), 2);
    check("good_dt", 32'(data_type), 'h2A);
    check("good_sb_empty", sb.size(), 0);

    // Same packet, corrupted CRC
    put(8'h2A); put(8'h09); put(8'h00); put(8'h11);
    for (int i = 0; i < 9; i++) put(8'h31 + 8'(i), 1'b1);
    put(8'h92); put(8'h6F);
    check("bad_crc_pulse", 32'(crc_err), 1);
    idle(1);
    check("bad_crc_oneshot", 32'(crc_err), 0);
    idle(2);
    check("bad_ce_n", ce_n, 1);
    check("bad_pkt", 32'(pkt_count), 3);
    check("bad_pix_n", pix_n, 18);

    // Truncated long packet: 5 of 16 payload bytes
    put(8'h2A); put(8'h10); put(8'h00); put(8'h22);
    for (int i = 0; i < 5; i++) put(8'hA0 + 8'(i), 1'b1);
    idle(1);
    check("trunc_len_err", 32'(len_err), 1);
    check("trunc_pix_off", 32'(pix_valid), 0);
    idle(2);
    check("trunc_len_n", len_n, 1);
    check("trunc_pix_n", pix_n, 23);
    check("trunc_pkt", 32'(pkt_count), 3);
    put(8'h40); put(8'h01); put(8'h00); put(8'h23);
    idle(3);
    check("post_trunc_fs", fs_n, 2);
    check("post_trunc_vc", 32'(vchan), 1);
    check("post_trunc_pkt", 32'(pkt_count), 4);

    // Oversize WC, trailing bytes ignored
    put(8'h2A); put(8'h00); put(8'h02); put(8'h33);
    check("over_len_err", 32'(len_err), 1);
    put(8'h55); put(8'h55); put(8'h55);
    idle(3);
    check("over_len_n", len_n, 2);
    check("over_pix_n", pix_n, 23);
    check("over_pkt", 32'(pkt_count), 4);
    check("over_wc", 32'(word_count), 'h0200);

    // Zero-length long packet
    put(8'h2A); put(8'h00); put(8'h00); put(8'h44); put(8'hFF); put(8'hFF);
    check("zero_crc_err", 32'(crc_err), 0);
    idle(3);
    check("zero_ce_n", ce_n, 1);
    check("zero_pkt", 32'(pkt_count), 5);
    check("zero_pix_n", pix_n, 23);
    check("no_line_events", ls_n + le_n, 0);

    // Asynchronous reset during payload
    put(8'h2A); put(8'h10); put(8'h00); put(8'h55);
    for (int i = 0; i < 3; i++) put(8'h61 + 8'(i), 1'b1);
    @(negedge clk); #1;
    resetb = 1'b0;
    #1;
    check("arst_pix_valid", 32'(pix_valid), 0);
    check("arst_pkt", 32'(pkt_count), 0);
    check("arst_hdr", 32'({data_type, vchan, word_count, ecc}), 0);
    in_we = 1'b0;
    @(posedge clk); #1;
    resetb = 1'b1;
    idle(1);
    check("arst_pix_n", pix_n, 26);
    put(8'h01); put(8'h00); put(8'h00); put(8'h66);
    check("fe_pulse", 32'(frame_end), 1);
    idle(3);
    check("fe_count", fe_n, 1);
    check("fe_pkt", 32'(pkt_count), 1);
    check("final_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/csi2_packet_parser.md
Name: csi2_packet_parser

Overview:
- Single-lane CSI-2 packet layer that sits directly downstream of the MIPI D-PHY deserializer.
- Consumes the byte-aligned burst that the deserializer emits after the 0xB8 sync byte: a `we` strobe plus an 8-bit data byte, clock domain = byte clock.
- Decodes the packet header and emits frame/line events and payload bytes.
- Checks the long-packet CRC-16 and length, and counts packets for status registers.

Parameters:
- CHECK_CRC, 1, 1 = compute and check payload CRC; 0 = crc_err tied 0 (CRC bytes still consumed).
- MAX_WC, 16'hFFFF, long packets with WC > MAX_WC are rejected with len_err; payload is suppressed.

Ports:
- clk  input  1  byte clock; same clock as the deserializer output.
- resetb  input  1  asynchronous active-low reset.
- in_we  input  1  byte valid from the PHY; high continuously for one HS burst.
- in_data  input  8  byte from the PHY, first byte after sync.
- frame_start  output  1  one-cycle pulse on an FS short packet (DT 0x00).
- frame_end  output  1  one-cycle pulse on an FE short packet (DT 0x01).
- line_start  output  1  one-cycle pulse on an LS short packet (DT 0x02).
- line_end  output  1  one-cycle pulse on an LE short packet (DT 0x03).
- pix_valid  output  1  payload byte valid.
- pix_data  output  8  payload byte.
- data_type  output  6  DI[5:0] of the current/last packet.
- vchan  output  2  DI[7:6] of the current/last packet.
- word_count  output  16  WC of the current/last packet (short packet: data field).
- ecc  output  8  header byte 4, passed through unchecked.
- crc_err  output  1  one-cycle pulse on a CRC mismatch.
- len_err  output  1  one-cycle pulse on a truncated burst or WC > MAX_WC.
- pkt_count  output  16  packets completed, wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (async, resetb low): all outputs are 0, the state is IDLE, and the CRC register is 16'hFFFF.
- Byte order on the wire: DI, WC_L, WC_H, ECC, payload[WC], CRC_L, CRC_H.
- States and transitions:
  - IDLE: on in_we=1, latch DI into vchan/data_type and go to HDR with hdr_cnt=1.
  - HDR: each in_we byte increments hdr_cnt.
    - Byte 1 loads WC[7:0]; byte 2 loads WC[15:8]; byte 3 loads ecc.
    - After byte 3: if DT <= 0x0F it is a short packet: pulse the matching event (DT 0x04-0x0F raise no pulse), increment pkt_count, go to DRAIN.
    - Else if WC > MAX_WC: pulse len_err, go to DRAIN.
    - Else if WC == 0: go to CRC.
    - Else: go to PAYLOAD with a remaining-byte counter set to WC.
  - PAYLOAD:
    - Each in_we byte produces pix_valid=1 and pix_data=byte on the next cycle, feeds the CRC, and decrements the counter.
    - When the counter reaches 0, go to CRC.
  - CRC:
    - Capture CRC_L, then CRC_H.
    - After CRC_H: compare against the computed CRC; on mismatch (and CHECK_CRC=1) pulse crc_err.
    - Increment pkt_count regardless of the CRC result, then go to DRAIN.
  - DRAIN: ignore bytes (trailer/filler) until in_we=0, then go to IDLE.
- in_we=0 while in HDR, PAYLOAD or CRC is a truncated burst:
  - Pulse len_err the next cycle and go directly to IDLE.
  - pkt_count does not increment.
  - pix_valid deasserts immediately on the next cycle.
- in_we=0 while in IDLE or DRAIN: return to or stay in IDLE, with no error.
- CRC definition:
  - CRC-16, polynomial x^16+x^12+x^5+1, reflected form 0x8408.
  - Init 16'hFFFF, processed LSB-first per byte, no final XOR.
  - Reset to FFFF on entering HDR.
  - Computed over payload bytes only; the received CRC is {CRC_H, CRC_L}.
- Latency: all outputs are registered, one cycle after the accepting in_we edge. Event pulses align with the cycle after ECC is accepted.
- data_type/vchan/word_count hold until the next packet's DI/WC is loaded.
- The block has no back-pressure. A byte is never dropped while in_we=1.
- Pulses never overlap within one packet: only one of frame_start, frame_end, line_start, line_end, crc_err or len_err fires per packet.

Test Plan:
- FS short packet: burst 00 01 00 xx, then we low -> frame_start single pulse; word_count=0x0001, vchan=0, pkt_count=1; no pix_valid.
- Long packet:
  - Burst 2A 09 00 xx, then payload "123456789" (31..39), then 91 6F -> nine pix_valid cycles carrying 31..39 in order; no crc_err; pkt_count increments; data_type=0x2A.
  - Same packet with CRC bytes 92 6F -> crc_err pulse one cycle after CRC_H; pkt_count still increments.
- Truncation: long header with WC=0x0010; drop in_we after 5 payload bytes -> exactly 5 pix_valid, a len_err pulse, return to IDLE; the next FS packet decodes correctly.
- Oversize and zero-length:
  - MAX_WC=0x0100, WC=0x0200 -> len_err; no pix_valid; trailing bytes ignored until we low.
  - WC=0 with CRC FF FF -> no crc_err, no pix_valid.
- Reset mid-payload: assert resetb low during PAYLOAD -> all outputs 0 asynchronously; pkt_count=0; the following FE packet produces frame_end.
